aes_inv_key_sched: RTL



---
 rtl/aes_ks_pkg.sv | 59 +++++
 rtl/aes_inv_key_sched_if.sv | 27 ++
 rtl/ks_subword.sv | 21 ++
 rtl/aes_inv_key_sched.sv | 122 ++++++++++++
 4 files changed

// File: rtl/aes_ks_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_ks_pkg
// Brief  : Shared types, round constants and byte helpers for the AES-128
//          inverse key schedule.
// Rev    : 1.0  initial release
// ============================================================================
package aes_ks_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_e;

    localparam logic [7:0] c_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] c_INV_EXP = 8'hfe;

    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        if (idx >= 4'd1 && idx <= 4'd10) begin
            return c_RCON[idx];
        end
        return 8'h00;
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box lookup: multiplicative inverse as x^254 (maps 0 to 0), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (c_INV_EXP[i]) r = gf_mul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_key_sched_if.sv
`default_nettype none
// ============================================================================
// Module : aes_inv_key_sched_if
// Brief  : Cipher-key input stream and round-key output stream bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface aes_inv_key_sched_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_last;

    modport master (
        output key_valid, key, rk_ready,
        input  key_ready, rk_valid, rk, rk_idx, rk_last
    );

    modport slave (
        input  key_valid, key, rk_ready,
        output key_ready, rk_valid, rk, rk_idx, rk_last
    );
endinterface
`default_nettype wire

// File: rtl/ks_subword.sv
`default_nettype none
// ============================================================================
// Module : ks_subword
// Brief  : Combinational 32-bit SubWord, one S-box lookup per byte.
// Rev    : 1.0  initial release
// ============================================================================
module ks_subword
    import aes_ks_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    generate
        for (genvar b = 0; b < 4; b++) begin : g_byte
            assign word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
// Module : aes_inv_key_sched
// Brief  : AES-128 key schedule expanded forward to round 10, then walked
//          backwards to emit round keys 10..0 on a valid/ready stream.
// Rev    : 1.0  initial release
// ============================================================================
module aes_inv_key_sched
    import aes_ks_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    aes_inv_key_sched_if.slave  bus
);

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] w_q, w_d;
    logic         rk_valid_q, rk_valid_d;
    logic         rk_last_q, rk_last_d;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_v1, w_v2, w_v3;
    logic [31:0]  w_sub_in, w_sub_out, w_t;
    logic [3:0]   w_rcon_idx;
    logic [127:0] w_fwd, w_bwd;

    assign {w_w0, w_w1, w_w2, w_w3} = w_q;

    assign w_v3 = w_w3 ^ w_w2;
    assign w_v2 = w_w2 ^ w_w1;
    assign w_v1 = w_w1 ^ w_w0;

    // One SubWord shared by both directions; EXPAND and EMIT never overlap.
    assign w_sub_in   = (state_q == EXPAND) ? w_w3 : w_v3;
    assign w_rcon_idx = (state_q == EXPAND) ? 4'(round_q + 4'd1) : round_q;

    ks_subword u_subword (
        .word_i (rotword(w_sub_in)),
        .word_o (w_sub_out)
    );

    assign w_t = w_sub_out ^ {rcon_byte(w_rcon_idx), 24'h000000};

    always_comb begin
        logic [31:0] f0, f1, f2, f3;
        f0    = w_w0 ^ w_t;
        f1    = w_w1 ^ f0;
        f2    = w_w2 ^ f1;
        f3    = w_w3 ^ f2;
        w_fwd = {f0, f1, f2, f3};
        w_bwd = {w_w0 ^ w_t, w_v1, w_v2, w_v3};
    end

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        w_d        = w_q;
        rk_valid_d = rk_valid_q;
        rk_last_d  = rk_last_q;
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    w_d     = bus.key;
                    round_d = 4'd0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                w_d     = w_fwd;
                round_d = 4'(round_q + 4'd1);
                if (round_q == 4'd9) begin
                    state_d    = EMIT;
                    rk_valid_d = 1'b1;
                    rk_last_d  = 1'b0;
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (round_q != 4'd0) begin
                        w_d       = w_bwd;
                        round_d   = 4'(round_q - 4'd1);
                        rk_last_d = (round_q == 4'd1);
                    end else begin
                        state_d    = IDLE;
                        rk_valid_d = 1'b0;
                        rk_last_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                rk_valid_d = 1'b0;
                rk_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            round_q    <= 4'd0;
            w_q        <= '0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            w_q        <= w_d;
            rk_valid_q <= rk_valid_d;
            rk_last_q  <= rk_last_d;
        end
    end

    assign bus.key_ready = (state_q == IDLE);
    assign bus.rk_valid  = rk_valid_q;
    assign bus.rk        = w_q;
    assign bus.rk_idx    = round_q;
    assign bus.rk_last   = rk_last_q;

endmodule
`default_nettype wire
